// File: rtl/srf05_ranger_if.sv
// Host/sensor-facing signal bundle of the SRF05 ranger; master = ranger, slave = host + sensor side.
interface srf05_ranger_if;
  logic        start;
  logic        echo;
  logic        trigger;
  logic [14:0] distance;
  logic        new_data;
  logic        busy;
  logic        timeout;
  logic [7:0]  timeout_count;

  modport master (input start, echo,
                  output trigger, distance, new_data, busy, timeout, timeout_count);
  modport slave  (output start, echo,
                  input trigger, distance, new_data, busy, timeout, timeout_count);
endinterface

// File: rtl/srf05_ranger.sv
// SRF05 ultrasonic ranger: trigger pulse, echo width in us, new_data strobe, timeout tracking.
// Optional median-of-3 output filter enabled by defining SRF05_MEDIAN_EN.
module srf05_ranger #(
  parameter int CLKS_PER_US     = 100,
  parameter int TRIG_US         = 12,
  parameter int RISE_TIMEOUT_US = 5000,
  parameter int ECHO_MAX_US     = 32000,
  parameter int HOLDOFF_US      = 50000
) (
  input  logic           clock,
  input  logic           reset,
  srf05_ranger_if.master bus
);
  localparam int MAX_A  = (TRIG_US > RISE_TIMEOUT_US) ? TRIG_US : RISE_TIMEOUT_US;
  localparam int MAX_B  = (ECHO_MAX_US > HOLDOFF_US) ? ECHO_MAX_US : HOLDOFF_US;
  localparam int MAX_US = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // Shared us counter must cover the holdoff, which can exceed the 15-bit distance range.
  localparam int CW_RAW = $clog2(MAX_US + 1);
  localparam int CW     = (CW_RAW < 15) ? 15 : CW_RAW;
  localparam int DW     = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [14:0] SAT = 15'h7FFF;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;
  logic          tick;
  logic          echo_s1, echo_s2, echo_d;
  logic          rise, fall;
  logic          meas_done;
  logic [14:0]   raw, dist_val;

  always_ff @(posedge clock) begin
    if (reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      echo_s1 <= bus.echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  assign tick      = (div == DW'(CLKS_PER_US - 1));
  assign rise      = echo_s2 & ~echo_d;
  assign fall      = ~echo_s2 & echo_d;
  assign cnt_inc   = {1'b0, cnt} + {{CW{1'b0}}, tick};
  assign meas_done = (state == MEASURE) &&
                     (fall || (tick && cnt == CW'(ECHO_MAX_US - 1)));

  // Include the tick landing on the fall cycle so the width is exact in whole us.
  always_comb begin
    raw = SAT;
    if (fall) raw = (cnt_inc > (CW+1)'(32767)) ? SAT : cnt_inc[14:0];
  end

`ifdef SRF05_MEDIAN_EN
  // Two previous readings; the incoming reading completes the 3-deep window.
  logic [14:0] hist0, hist1;
  logic        hist_vld;

  function automatic logic [14:0] med3(input logic [14:0] a, b, c);
    logic [14:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      hist0    <= '0;
      hist1    <= '0;
      hist_vld <= 1'b0;
    end else if (meas_done) begin
      hist_vld <= 1'b1;
      hist1    <= hist_vld ? hist0 : raw;
      hist0    <= raw;
    end
  end

  assign dist_val = hist_vld ? med3(raw, hist0, hist1) : raw;
`else
  assign dist_val = raw;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      div               <= '0;
      cnt               <= '0;
      bus.trigger       <= 1'b0;
      bus.distance      <= '0;
      bus.new_data      <= 1'b0;
      bus.busy          <= 1'b0;
      bus.timeout       <= 1'b0;
      bus.timeout_count <= '0;
    end else begin
      bus.new_data <= 1'b0;
      bus.timeout  <= 1'b0;
      div          <= tick ? '0 : div + DW'(1);
      if (tick && cnt != '1) cnt <= cnt + CW'(1);
      // Every transition below clears div/cnt so the new state times from zero.
      case (state)
        IDLE: if (bus.start) begin
          state       <= TRIG;
          bus.trigger <= 1'b1;
          bus.busy    <= 1'b1;
          div         <= '0;
          cnt         <= '0;
        end
        TRIG: if (tick && cnt == CW'(TRIG_US - 1)) begin
          state       <= WAIT_RISE;
          bus.trigger <= 1'b0;
          div         <= '0;
          cnt         <= '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state <= MEASURE;
            div   <= '0;
            cnt   <= '0;
          end else if (tick && cnt == CW'(RISE_TIMEOUT_US - 1)) begin
            state       <= HOLDOFF;
            bus.timeout <= 1'b1;
            if (bus.timeout_count != 8'hFF) bus.timeout_count <= bus.timeout_count + 8'd1;
            div <= '0;
            cnt <= '0;
          end
        end
        MEASURE: if (meas_done) begin
          state        <= HOLDOFF;
          bus.distance <= dist_val;
          bus.new_data <= 1'b1;
          div          <= '0;
          cnt          <= '0;
        end
        HOLDOFF: if (tick && cnt == CW'(HOLDOFF_US - 1)) begin
          div <= '0;
          cnt <= '0;
          if (bus.start) begin
            state       <= TRIG;
            bus.trigger <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          bus.trigger <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_srf05_ranger.sv
// Bench for srf05_ranger: directed + randomized pings checked against a us-level behavioural model.
module tb_srf05_ranger;
  localparam int CPU = 4, TRIG = 12, RTO = 50, EMAX = 200, HOLD = 100;
  localparam int P = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  srf05_ranger_if bus ();
  srf05_ranger_if fbus ();

  srf05_ranger #(.CLKS_PER_US(CPU), .TRIG_US(TRIG), .RISE_TIMEOUT_US(RTO),
                 .ECHO_MAX_US(EMAX), .HOLDOFF_US(HOLD))
    dut (.clock(clock), .reset(reset), .bus(bus));

  // Tiny timing so 300 consecutive timeouts fit in a short run.
  srf05_ranger #(.CLKS_PER_US(1), .TRIG_US(2), .RISE_TIMEOUT_US(3),
                 .ECHO_MAX_US(200), .HOLDOFF_US(2))
    fast (.clock(clock), .reset(reset), .bus(fbus));

  int n_cmp = 0, n_bad = 0;

  // Behavioural model state: raw echo readings since reset and timeout count.
  int raw_q[$];
  int to_model = 0;

  // Event log, sampled on the falling edge.
  time tr_rise[$], tr_fall[$], nd_t[$], to_t[$];
  int  nd_val[$];
  logic trig_q = 1'b0, nd_q = 1'b0, to_q = 1'b0;
  int  both = 0, wide = 0;
  int  f_to = 0, f_c254 = -1, f_c255 = -1;

  always @(negedge clock) begin
    if (bus.trigger === 1'b1 && trig_q !== 1'b1) tr_rise.push_back($time);
    if (bus.trigger === 1'b0 && trig_q === 1'b1) tr_fall.push_back($time);
    trig_q = bus.trigger;
    if (bus.new_data === 1'b1) begin
      nd_t.push_back($time);
      nd_val.push_back(int'(bus.distance));
    end
    if (bus.timeout === 1'b1) to_t.push_back($time);
    if (bus.new_data === 1'b1 && bus.timeout === 1'b1) both++;
    if ((bus.new_data === 1'b1 && nd_q === 1'b1) || (bus.timeout === 1'b1 && to_q === 1'b1)) wide++;
    nd_q = bus.new_data;
    to_q = bus.timeout;
    if (fbus.timeout === 1'b1) begin
      f_to++;
      if (f_to == 254) f_c254 = int'(fbus.timeout_count);
      if (f_to == 255) f_c255 = int'(fbus.timeout_count);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  function automatic int model_dist();
    int w[$];
    if (raw_q.size() == 0) return 0;
`ifdef SRF05_MEDIAN_EN
    w.push_back(raw_q[raw_q.size()-1]);
    w.push_back(raw_q.size() >= 2 ? raw_q[raw_q.size()-2] : raw_q[0]);
    w.push_back(raw_q.size() >= 3 ? raw_q[raw_q.size()-3] : raw_q[0]);
    w.sort();
    return w[1];
`else
    return raw_q[raw_q.size()-1];
`endif
  endfunction

  // One measurement cycle. dly<0: echo never rises. Returns once the next trigger is seen
  // (start=1) or after the return to idle has been checked (start=0).
  task automatic ping(input int dly, input int w, input string tag);
    int nf, nn, nt, nr;
    time tf, tev, trs;
    bit got;
    nf = tr_fall.size(); nn = nd_t.size(); nt = to_t.size();
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin step(); got = (tr_fall.size() > nf); end
    chk({tag, "_trig_fall_seen"}, got, 1);
    if (!got) return;
    tf = tr_fall[nf];
    chk({tag, "_trig_width"}, tf - tr_rise[tr_rise.size()-1], TRIG*CPU*P);
    nr = tr_rise.size();
    if (dly < 0) begin
      got = 0;
      for (int i = 0; i < 1000 && !got; i++) begin step(); got = (to_t.size() > nt); end
      chk({tag, "_timeout_seen"}, got, 1);
      if (!got) return;
      tev = to_t[nt];
      to_model++;
      chk({tag, "_timeout_lat"}, tev - tf, RTO*CPU*P);
      chk({tag, "_timeout_count"}, bus.timeout_count, (to_model > 255) ? 255 : to_model);
      chk({tag, "_no_new_data"}, nd_t.size(), nn);
      chk({tag, "_dist_held"}, bus.distance, model_dist());
    end else begin
      repeat (dly*CPU) step();
      bus.echo = 1'b1;
      trs = $time - 1;
      repeat (w*CPU) step();
      bus.echo = 1'b0;
      got = (nd_t.size() > nn);
      for (int i = 0; i < 100 && !got; i++) begin step(); got = (nd_t.size() > nn); end
      chk({tag, "_nd_seen"}, got, 1);
      if (!got) return;
      tev = nd_t[nn];
      raw_q.push_back(w >= EMAX ? 32767 : w);
      chk({tag, "_nd_once"}, nd_t.size(), nn + 1);
      chk({tag, "_distance"}, nd_val[nn], model_dist());
      // Saturation: EMAX us of counting plus 2-flop sync and the registered strobe.
      if (w > EMAX) chk({tag, "_sat_lat"}, tev - trs, (EMAX*CPU + 3)*P);
    end
    if (bus.start) begin
      got = (tr_rise.size() > nr);
      for (int i = 0; i < 1000 && !got; i++) begin step(); got = (tr_rise.size() > nr); end
      chk({tag, "_next_trig_seen"}, got, 1);
      if (got) chk({tag, "_holdoff"}, tr_rise[nr] - tev, HOLD*CPU*P);
    end else begin
      repeat (HOLD*CPU - 2) step();
      chk({tag, "_busy_in_holdoff"}, bus.busy, 1);
      repeat (4) step();
      chk({tag, "_busy_idle"}, bus.busy, 0);
      chk({tag, "_single_trig"}, tr_rise.size(), nr);
    end
  endtask

  initial begin
    int nn, nr, nf, sel, dly, w;
    int exp6[3];
    bit got;
    bus.start = 1'b0; bus.echo = 1'b0;
    fbus.start = 1'b0; fbus.echo = 1'b0;
    repeat (3) step();
    chk("rst_trigger", bus.trigger, 0);
    chk("rst_distance", bus.distance, 0);
    chk("rst_new_data", bus.new_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_timeout_count", bus.timeout_count, 0);
    reset = 1'b0;
    step();

    bus.start = 1'b1;
    ping(20, 150, "t1_basic");
    chk("t1_busy", bus.busy, 1);
    ping(-1, 0, "t2_timeout");
    ping(10, 300, "t3_sat");
    // Echo already high before WAIT_RISE: no rise, so this cycle must time out.
    bus.echo = 1'b1;
    ping(-1, 0, "t3_stuck_high");
    bus.echo = 1'b0;

    for (int k = 0; k < 8; k++) begin
      sel = int'($urandom_range(0, 9));
      dly = int'($urandom_range(1, 40));
      w   = (sel < 2) ? int'($urandom_range(201, 260)) : int'($urandom_range(1, 198));
      if (sel == 0) ping(-1, 0, "rnd_to");
      else ping(dly, w, "rnd");
    end

    // Reset in the middle of a measurement.
    nf = tr_fall.size();
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin step(); got = (tr_fall.size() > nf); end
    chk("t4_trig_fall_seen", got, 1);
    repeat (5*CPU) step();
    bus.echo = 1'b1;
    repeat (40*CPU) step();
    bus.start = 1'b0;
    nn = nd_t.size();
    reset = 1'b1;
    step();
    chk("t4_trigger", bus.trigger, 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_new_data", bus.new_data, 0);
    chk("t4_distance", bus.distance, 0);
    chk("t4_timeout_count", bus.timeout_count, 0);
    reset = 1'b0;
    raw_q.delete();
    to_model = 0;
    nr = tr_rise.size();
    repeat (200*CPU) step();
    chk("t4_no_strobe", nd_t.size(), nn);
    chk("t4_stays_idle", tr_rise.size(), nr);
    chk("t4_busy_idle", bus.busy, 0);
    bus.echo = 1'b0;
    step();

    // Single-cycle start pulse: one full cycle, then idle.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("t5_restart_trig", tr_rise.size(), nr + 1);
    ping(-1, 0, "t5_pulse");

    // Median filter sequence from a clean history.
    reset = 1'b1;
    step();
    reset = 1'b0;
    raw_q.delete();
    to_model = 0;
`ifdef SRF05_MEDIAN_EN
    exp6[0] = 100; exp6[1] = 100; exp6[2] = 120;
`else
    exp6[0] = 100; exp6[1] = 180; exp6[2] = 120;
`endif
    nn = nd_t.size();
    bus.start = 1'b1;
    ping(15, 100, "t6_a");
    ping(15, 180, "t6_b");
    ping(15, 120, "t6_c");
    bus.start = 1'b0;
    if (nd_t.size() >= nn + 3)
      for (int k = 0; k < 3; k++) chk($sformatf("t6_dist%0d", k), nd_val[nn+k], exp6[k]);
    else chk("t6_count", nd_t.size(), nn + 3);

    // Saturating timeout counter.
    fbus.start = 1'b1;
    for (int i = 0; i < 20000 && f_to < 300; i++) step();
    chk("t5_300_timeouts", f_to >= 300, 1);
    chk("t5_count_254", f_c254, 254);
    chk("t5_count_255", f_c255, 255);
    chk("t5_count_hold", fbus.timeout_count, 255);
    fbus.start = 1'b0;

    chk("strobe_overlap", both, 0);
    chk("strobe_width", wide, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
